mem_arbiter: RTL

Sequential arbiter for the single byte-wide memory port shared by instruction fetch (IF) and load/store (MEM). Serialises each 1/2/4-byte access into byte transfers, returns assembled little-endian words, and raises per-requester stall requests. These are the inputs to the pipeline stall vector that freezes or bubbles IF_ID…MEM_WB.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: FSM states, owner codes, length codes.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Unsupported length codes fall back to a full word.
  function automatic logic [2:0] len_decode(
    input logic [2:0] code
  );
    logic [2:0] n;
    unique case (1'b1)
      (code == LEN_B): n = LEN_B;
      (code == LEN_H): n = LEN_H;
      default:         n = LEN_W;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the shared IF/MEM memory port.
// Define MEM_ARB_FAIR_EN to alternate grants on simultaneous requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_done_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [2:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_done_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_wr_out,
  output logic [7:0]        ram_data_out,
  input  logic [7:0]        ram_data_in,
  output logic              stall_req_if_out,
  output logic              stall_req_mem_out
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        k_q, k_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;

  logic              grant_mem;
  logic              any_req;
  logic [2:0]        k_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        wd_byte;
  logic [DATA_W-1:0] lane_in;

`ifdef MEM_ARB_FAIR_EN
  owner_e last_q, last_d;

  assign grant_mem = mem_req_in &
                     (~if_req_in | (last_q == OWN_IF));

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && any_req) begin
      last_d = grant_mem ? OWN_MEM : OWN_IF;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) last_q <= OWN_IF;
    else         last_q <= last_d;
  end
`else
  assign grant_mem = mem_req_in;
`endif

  assign any_req  = mem_req_in | if_req_in;
  assign k_nx     = k_q + 3'd1;
  assign req_addr = grant_mem ? mem_addr_in : if_addr_in;
  assign wd_byte  = 8'(wdata_q >> {k_nx, 3'b000});
  // Byte returned now belongs to the address issued last cycle.
  assign lane_in  = DATA_W'(ram_data_in) << {k_q - 3'd1, 3'b000};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    n_d         = n_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    buf_d       = buf_q;
    addr_d      = addr_q;
    wr_d        = 1'b0;
    wbyte_d     = wbyte_q;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_XFER;
          owner_d = grant_mem ? OWN_MEM : OWN_IF;
          base_d  = req_addr;
          n_d     = grant_mem ? len_decode(mem_len_in)
                              : LEN_W;
          we_d    = grant_mem & mem_we_in;
          wdata_d = mem_wdata_in;
          k_d     = '0;
          buf_d   = '0;
          addr_d  = req_addr;
          wr_d    = grant_mem & mem_we_in;
          wbyte_d = mem_wdata_in[7:0];
        end
      end
      ST_XFER: begin
        if (owner_q == OWN_IF && !if_req_in) begin
          state_d = ST_IDLE;
        end else if (we_q) begin
          if (k_nx < n_q) begin
            addr_d  = base_q + ADDR_W'(k_nx);
            wr_d    = 1'b1;
            wbyte_d = wd_byte;
            k_d     = k_nx;
          end else begin
            state_d    = ST_DONE;
            mem_done_d = 1'b1;
          end
        end else begin
          if (k_q != 3'd0) buf_d = buf_q | lane_in;
          if (k_nx < n_q) begin
            addr_d = base_q + ADDR_W'(k_nx);
          end
          if (k_q == n_q) begin
            state_d = ST_DONE;
            if (owner_q == OWN_IF) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end
          end else begin
            k_d = k_nx;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      n_q         <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      k_q         <= '0;
      buf_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wbyte_q     <= '0;
      if_data_q   <= '0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      n_q         <= n_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wbyte_q     <= wbyte_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_data_out       = if_data_q;
  assign if_done_out       = if_done_q;
  assign mem_rdata_out     = mem_rdata_q;
  assign mem_done_out      = mem_done_q;
  assign ram_addr_out      = addr_q;
  assign ram_wr_out        = wr_q;
  assign ram_data_out      = wbyte_q;
  assign stall_req_if_out  = if_req_in & ~if_done_q;
  assign stall_req_mem_out = mem_req_in & ~mem_done_q;

endmodule
